// File: rtl/rvvi_frame_packer_if.sv
// rtl/rvvi_frame_packer_if.sv - record input and AXI write-data channel bundle for rvvi_frame_packer
//
// Purpose: groups the core-side record handshake and the MAC-side AXI W beat
// channel into one bundle.
// Ports (signals):
//   rvvi / RvviValid / RvviReady            record offered by the core, FIFO not full
//   RvviAxiWdata / RvviAxiWstrb             beat data, byte strobes (all ones)
//   RvviAxiWlast / RvviAxiWvalid            last beat of frame, beat valid
//   RvviAxiWready                           sink ready
// Modports: master = packer side, slave = core/MAC side.

interface rvvi_frame_packer_if #(
    parameter int RVVI_WIDTH = 328,
    parameter int DATA_WIDTH = 32
);
    logic [RVVI_WIDTH-1:0]   rvvi;
    logic                    RvviValid;
    logic                    RvviReady;
    logic [DATA_WIDTH-1:0]   RvviAxiWdata;
    logic [DATA_WIDTH/8-1:0] RvviAxiWstrb;
    logic                    RvviAxiWlast;
    logic                    RvviAxiWvalid;
    logic                    RvviAxiWready;

    modport master (
        input  rvvi, RvviValid, RvviAxiWready,
        output RvviReady, RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast, RvviAxiWvalid
    );

    modport slave (
        output rvvi, RvviValid, RvviAxiWready,
        input  RvviReady, RvviAxiWdata, RvviAxiWstrb, RvviAxiWlast, RvviAxiWvalid
    );
endinterface

// File: rtl/rvvi_frame_packer.sv
// rtl/rvvi_frame_packer.sv - buffers RVVI records and packs them into AXI-burst Ethernet frames
//
// Purpose: records are queued in a FIFO; once INSTRS_PER_FRAME are present (or the
// flush timer expires on a partial batch) a frame of a 208-bit header followed by
// NInstr zero-padded records is streamed out low word first.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   bus (master)        record input handshake and AXI W beat channel
//   SrcMac, DstMac      MAC addresses, registered at header entry
//   EthType, AckType    header fields, registered at header entry
//   InnerPktDelay       minimum idle cycles between frames (live)
//   FlushTimeout        idle cycles before a partial frame goes out, 0 = never (live)
//   FrameCount          completed frames, wraps modulo 2^64

module rvvi_frame_packer #(
    parameter int          RVVI_WIDTH       = 328,
    parameter int          DATA_WIDTH       = 32,
    parameter int          FIFO_DEPTH       = 16,
    parameter int          INSTRS_PER_FRAME = 4,
    parameter logic [31:0] INIT_TIME_OUT    = 32'd4
) (
    input  logic                clk,
    input  logic                reset,
    rvvi_frame_packer_if.master bus,
    input  logic [47:0]         SrcMac,
    input  logic [47:0]         DstMac,
    input  logic [15:0]         EthType,
    input  logic [15:0]         AckType,
    input  logic [31:0]         InnerPktDelay,
    input  logic [31:0]         FlushTimeout,
    output logic [63:0]         FrameCount
);
    localparam int HEAD_BITS  = 208;
    localparam int HEAD_WORDS = (HEAD_BITS + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int REC_WORDS  = (RVVI_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int HEAD_PAD   = HEAD_WORDS * DATA_WIDTH;
    localparam int REC_PAD    = REC_WORDS * DATA_WIDTH;
    localparam int AW         = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_COLLECT,
        ST_HEADER,
        ST_RECORD,
        ST_GAP
    } state_t;

    state_t r_state, w_next;

    logic [RVVI_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr, r_rd_ptr;
    logic [31:0]           r_cnt;
    logic [7:0]            r_beat, r_rec, r_ninstr;
    logic [HEAD_PAD-1:0]   r_head;
    logic [63:0]           r_frame_count;

    logic [AW:0]           w_count;
    logic                  w_full, w_push, w_pop, w_accept;
    logic                  w_thresh, w_flush;
    logic                  w_head_last_word, w_rec_last_word, w_last_rec;
    logic [7:0]            w_ninstr_next;
    logic [REC_PAD-1:0]    w_rec_pad;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_full   = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_push   = bus.RvviValid & ~w_full;
    assign w_accept = bus.RvviAxiWvalid & bus.RvviAxiWready;

    assign w_head_last_word = (r_beat == 8'(HEAD_WORDS - 1));
    assign w_rec_last_word  = (r_beat == 8'(REC_WORDS - 1));
    assign w_last_rec       = (r_rec == r_ninstr - 8'd1);
    assign w_pop            = w_accept & (r_state == ST_RECORD) & w_rec_last_word;

    assign w_thresh      = (32'(w_count) >= 32'(INSTRS_PER_FRAME));
    assign w_flush       = (w_count != '0) && (FlushTimeout != 32'd0) && (r_cnt >= FlushTimeout);
    assign w_ninstr_next = w_thresh ? 8'(INSTRS_PER_FRAME) : 8'(w_count);

    assign w_rec_pad = REC_PAD'(r_mem[r_rd_ptr[AW-1:0]]);

    // Outputs depend only on registered state, so Wdata/Wlast hold while Wready is low.
    assign bus.RvviReady     = ~w_full;
    assign bus.RvviAxiWstrb  = '1;
    assign bus.RvviAxiWvalid = (r_state == ST_HEADER) || (r_state == ST_RECORD);
    assign bus.RvviAxiWlast  = (r_state == ST_RECORD) && w_rec_last_word && w_last_rec;
    assign bus.RvviAxiWdata  = (r_state == ST_HEADER) ? r_head[int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] :
                               (r_state == ST_RECORD) ? w_rec_pad[int'(r_beat)*DATA_WIDTH +: DATA_WIDTH] :
                               '0;
    assign FrameCount = r_frame_count;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_STARTUP;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_STARTUP: if (r_cnt == INIT_TIME_OUT)                  w_next = ST_COLLECT;
            ST_COLLECT: if (w_thresh || w_flush)                     w_next = ST_HEADER;
            ST_HEADER:  if (w_accept && w_head_last_word)            w_next = ST_RECORD;
            ST_RECORD:  if (w_accept && w_rec_last_word && w_last_rec) w_next = ST_GAP;
            ST_GAP:     if (r_cnt >= InnerPktDelay)                  w_next = ST_COLLECT;
            default:                                                 w_next = ST_STARTUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.rvvi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_cnt         <= '0;
            r_beat        <= '0;
            r_rec         <= '0;
            r_ninstr      <= '0;
            r_head        <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            // One counter serves startup, flush idle time and the inter-frame gap;
            // it restarts on every state change and saturates instead of wrapping.
            if (r_state != w_next)
                r_cnt <= '0;
            else if (r_state == ST_COLLECT && w_count == '0)
                r_cnt <= '0;
            else if (r_cnt != '1)
                r_cnt <= r_cnt + 32'd1;

            if (r_state == ST_COLLECT && w_next == ST_HEADER) begin
                r_ninstr <= w_ninstr_next;
                r_head   <= HEAD_PAD'({w_ninstr_next, 8'h00, r_frame_count, AckType, EthType, DstMac, SrcMac});
                r_beat   <= '0;
                r_rec    <= '0;
            end else if (w_accept) begin
                if (r_state == ST_HEADER) begin
                    r_beat <= w_head_last_word ? 8'd0 : r_beat + 8'd1;
                end else if (w_rec_last_word) begin
                    r_beat <= '0;
                    r_rec  <= r_rec + 8'd1;
                    if (w_last_rec) r_frame_count <= r_frame_count + 64'd1;
                end else begin
                    r_beat <= r_beat + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rvvi_frame_packer.sv
// tb/tb_rvvi_frame_packer.sv - directed self-checking bench for rvvi_frame_packer

module tb_rvvi_frame_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] src_mac = 48'h0A0B0C0D0E0F;
    logic [47:0] dst_mac = 48'h112233445566;
    logic [15:0] eth_type = 16'h88B5;
    logic [15:0] ack_type = 16'h1234;
    logic [31:0] gap_dly;
    logic [31:0] flush_to;
    logic [63:0] fc32, fc64;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rvvi_frame_packer_if #(.RVVI_WIDTH(328), .DATA_WIDTH(32)) bus32 ();
    rvvi_frame_packer_if #(.RVVI_WIDTH(328), .DATA_WIDTH(64)) bus64 ();

    rvvi_frame_packer #(.RVVI_WIDTH(328), .DATA_WIDTH(32), .FIFO_DEPTH(16),
                        .INSTRS_PER_FRAME(4), .INIT_TIME_OUT(32'd4)) u_dut32 (
        .clk(clk), .reset(reset), .bus(bus32.master),
        .SrcMac(src_mac), .DstMac(dst_mac), .EthType(eth_type), .AckType(ack_type),
        .InnerPktDelay(gap_dly), .FlushTimeout(flush_to), .FrameCount(fc32)
    );

    rvvi_frame_packer #(.RVVI_WIDTH(328), .DATA_WIDTH(64), .FIFO_DEPTH(16),
                        .INSTRS_PER_FRAME(4), .INIT_TIME_OUT(32'd4)) u_dut64 (
        .clk(clk), .reset(reset), .bus(bus64.master),
        .SrcMac(src_mac), .DstMac(dst_mac), .EthType(eth_type), .AckType(ack_type),
        .InnerPktDelay(gap_dly), .FlushTimeout(flush_to), .FrameCount(fc64)
    );

    logic [327:0] exp_q[$];
    logic [31:0]  exp_beats[$];
    logic [31:0]  rx_q[$];
    int rx_first, rx_last_c, rx_last_idx, rx_hold_bad, push_acc;

    // Word i of record k reads D0_kk_00_ii; the 11th word keeps only its low byte.
    function automatic logic [327:0] mk_rec(input int k);
        logic [351:0] t;
        for (int i = 0; i < 11; i++) t[i*32 +: 32] = {8'hD0, 8'(k), 8'h00, 8'(i)};
        return t[327:0];
    endfunction

    function automatic void build_frame(input int n, input logic [63:0] fc);
        logic [223:0] h;
        logic [351:0] r;
        exp_beats.delete();
        h = {16'h0, 8'(n), 8'h00, fc, ack_type, eth_type, dst_mac, src_mac};
        for (int i = 0; i < 7; i++) exp_beats.push_back(h[i*32 +: 32]);
        for (int j = 0; j < n; j++) begin
            r = {24'h0, exp_q.pop_front()};
            for (int w = 0; w < 11; w++) exp_beats.push_back(r[w*32 +: 32]);
        end
    endfunction

    task automatic push32(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus32.RvviValid = 1'b1;
            bus32.rvvi      = mk_rec(base + k);
            #1;
            if (bus32.RvviReady === 1'b1) begin
                exp_q.push_back(mk_rec(base + k));
                push_acc++;
            end
        end
        @(negedge clk);
        bus32.RvviValid = 1'b0;
        #1;
    endtask

    // Receives one frame; Wready drops for stall_len cycles while beat stall_beat is offered.
    task automatic rx32(input int stall_beat, input int stall_len, input int budget);
        int stalled;
        bit holding;
        logic [31:0] hd;
        logic hl;
        stalled = 0; holding = 0; hd = '0; hl = 1'b0;
        rx_q.delete(); rx_first = -1; rx_last_c = -1; rx_last_idx = -1; rx_hold_bad = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rx_q.size() == stall_beat && stalled < stall_len) begin
                bus32.RvviAxiWready = 1'b0;
                stalled++;
            end else begin
                bus32.RvviAxiWready = 1'b1;
            end
            #1;
            if (holding && (bus32.RvviAxiWdata !== hd || bus32.RvviAxiWlast !== hl || bus32.RvviAxiWvalid !== 1'b1))
                rx_hold_bad++;
            holding = 0;
            if (bus32.RvviAxiWvalid === 1'b1 && rx_first < 0) rx_first = c;
            if (bus32.RvviAxiWvalid === 1'b1 && bus32.RvviAxiWready === 1'b0) begin
                holding = 1; hd = bus32.RvviAxiWdata; hl = bus32.RvviAxiWlast;
            end
            if (bus32.RvviAxiWvalid === 1'b1 && bus32.RvviAxiWready === 1'b1) begin
                rx_q.push_back(bus32.RvviAxiWdata);
                if (bus32.RvviAxiWlast === 1'b1) begin
                    rx_last_idx = rx_q.size() - 1;
                    rx_last_c   = c;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({bus32.RvviReady, bus32.RvviAxiWvalid, bus32.RvviAxiWlast} !== 3'b100) begin
            n_bad++; $display("FAIL reset_flags: got %b want 100", {bus32.RvviReady, bus32.RvviAxiWvalid, bus32.RvviAxiWlast});
        end
        n_cmp++;
        if (bus32.RvviAxiWdata !== 32'h0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", bus32.RvviAxiWdata); end
        n_cmp++;
        if (bus32.RvviAxiWstrb !== 4'hF) begin n_bad++; $display("FAIL reset_wstrb: got %h want f", bus32.RvviAxiWstrb); end
        n_cmp++;
        if (bus64.RvviAxiWstrb !== 8'hFF) begin n_bad++; $display("FAIL reset_wstrb64: got %h want ff", bus64.RvviAxiWstrb); end
        n_cmp++;
        if (fc32 !== 64'd0) begin n_bad++; $display("FAIL reset_framecount: got %0d want 0", fc32); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_bus64();
        logic [63:0] b[$];
        int acc;
        acc = 0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus64.RvviValid = 1'b1;
            bus64.rvvi      = {41{8'hA5}};
            #1;
            if (bus64.RvviReady === 1'b1) acc++;
        end
        @(negedge clk);
        bus64.RvviValid = 1'b0;
        n_cmp++;
        if (acc !== 4) begin n_bad++; $display("FAIL b64_pushed: got %0d want 4", acc); end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus64.RvviAxiWready = 1'b1;
            #1;
            if (bus64.RvviAxiWvalid === 1'b1) begin
                b.push_back(bus64.RvviAxiWdata);
                if (bus64.RvviAxiWlast === 1'b1) break;
            end
        end
        n_cmp++;
        if (b.size() !== 28) begin n_bad++; $display("FAIL b64_len: got %0d want 28", b.size()); end
        if (b.size() == 28) begin
            n_cmp++;
            if (b[0] !== 64'h55660A0B0C0D0E0F) begin n_bad++; $display("FAIL b64_beat0: got %h want 55660a0b0c0d0e0f", b[0]); end
            n_cmp++;
            if (b[3] !== 64'h0000000000000400) begin n_bad++; $display("FAIL b64_ninstr: got %h want 400", b[3]); end
            n_cmp++;
            if (b[4] !== 64'hA5A5A5A5A5A5A5A5) begin n_bad++; $display("FAIL b64_rec0: got %h want a5a5a5a5a5a5a5a5", b[4]); end
            n_cmp++;
            if (b[9] !== 64'h00000000000000A5) begin n_bad++; $display("FAIL b64_pad: got %h want a5", b[9]); end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (fc64 !== 64'd1) begin n_bad++; $display("FAIL b64_framecount: got %0d want 1", fc64); end
    endtask

    task automatic test_full_frame();
        push_acc = 0;
        push32(4, 0);
        n_cmp++;
        if (push_acc !== 4) begin n_bad++; $display("FAIL full_pushed: got %0d want 4", push_acc); end
        n_cmp++;
        if (bus32.RvviAxiWvalid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid: got %b want 0", bus32.RvviAxiWvalid); end
        rx32(-1, 0, 200);
        n_cmp++;
        if (rx_first !== 0) begin n_bad++; $display("FAIL full_header_latency: got %0d want 0", rx_first); end
        n_cmp++;
        if (rx_last_c !== 50 || rx_last_idx !== 50) begin
            n_bad++; $display("FAIL full_wlast: got cycle %0d beat %0d want 50/50", rx_last_c, rx_last_idx);
        end
        build_frame(4, 64'd0);
        n_cmp++;
        if (rx_q.size() !== 51) begin n_bad++; $display("FAIL full_len: got %0d want 51", rx_q.size()); end
        if (rx_q.size() == 51) begin
            n_cmp++;
            if (rx_q[6] !== 32'h00000400) begin n_bad++; $display("FAIL full_ninstr: got %h want 00000400", rx_q[6]); end
            n_cmp++;
            if (rx_q[0] !== 32'h0C0D0E0F) begin n_bad++; $display("FAIL full_beat0: got %h want 0c0d0e0f", rx_q[0]); end
            for (int i = 0; i < 51; i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_beats[i]) begin n_bad++; $display("FAIL full_beat%0d: got %h want %h", i, rx_q[i], exp_beats[i]); end
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (fc32 !== 64'd1) begin n_bad++; $display("FAIL full_framecount: got %0d want 1", fc32); end
    endtask

    task automatic test_backpressure();
        push_acc = 0;
        push32(4, 10);
        rx32(12, 3, 200);
        n_cmp++;
        if (rx_hold_bad !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable samples want 0", rx_hold_bad); end
        n_cmp++;
        if (rx_last_c !== 53 || rx_last_idx !== 50) begin
            n_bad++; $display("FAIL bp_wlast: got cycle %0d beat %0d want 53/50", rx_last_c, rx_last_idx);
        end
        build_frame(4, 64'd1);
        n_cmp++;
        if (rx_q.size() !== 51) begin n_bad++; $display("FAIL bp_len: got %0d want 51", rx_q.size()); end
        if (rx_q.size() == 51) begin
            for (int i = 0; i < 51; i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_beats[i]) begin n_bad++; $display("FAIL bp_beat%0d: got %h want %h", i, rx_q[i], exp_beats[i]); end
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (fc32 !== 64'd2) begin n_bad++; $display("FAIL bp_framecount: got %0d want 2", fc32); end
    endtask

    task automatic test_fifo_full();
        bus32.RvviAxiWready = 1'b0;
        repeat (3) @(negedge clk);
        push_acc = 0;
        push32(20, 100);
        n_cmp++;
        if (push_acc !== 16) begin n_bad++; $display("FAIL ff_accepted: got %0d want 16", push_acc); end
        n_cmp++;
        if ({bus32.RvviReady, bus32.RvviAxiWvalid} !== 2'b01) begin
            n_bad++; $display("FAIL ff_ready_valid: got %b want 01", {bus32.RvviReady, bus32.RvviAxiWvalid});
        end
        n_cmp++;
        if (bus32.RvviAxiWdata !== 32'h0C0D0E0F) begin n_bad++; $display("FAIL ff_held_beat0: got %h want 0c0d0e0f", bus32.RvviAxiWdata); end
        for (int f = 0; f < 4; f++) begin
            rx32(-1, 0, 200);
            build_frame(4, 64'(2 + f));
            n_cmp++;
            if (rx_q.size() !== 51) begin n_bad++; $display("FAIL ff_len%0d: got %0d want 51", f, rx_q.size()); end
            if (rx_q.size() == 51) begin
                for (int i = 0; i < 51; i++) begin
                    n_cmp++;
                    if (rx_q[i] !== exp_beats[i]) begin n_bad++; $display("FAIL ff_f%0d_beat%0d: got %h want %h", f, i, rx_q[i], exp_beats[i]); end
                end
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (fc32 !== 64'd6) begin n_bad++; $display("FAIL ff_framecount: got %0d want 6", fc32); end
    endtask

    task automatic test_flush();
        int seen;
        flush_to = 32'd10;
        repeat (3) @(negedge clk);
        push32(1, 200);
        rx32(-1, 0, 100);
        n_cmp++;
        if (rx_first !== 10) begin n_bad++; $display("FAIL flush_latency: got %0d want 10", rx_first); end
        build_frame(1, 64'd6);
        n_cmp++;
        if (rx_q.size() !== 18) begin n_bad++; $display("FAIL flush_len: got %0d want 18", rx_q.size()); end
        if (rx_q.size() == 18) begin
            n_cmp++;
            if (rx_q[6] !== 32'h00000100) begin n_bad++; $display("FAIL flush_ninstr: got %h want 00000100", rx_q[6]); end
            for (int i = 0; i < 18; i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_beats[i]) begin n_bad++; $display("FAIL flush_beat%0d: got %h want %h", i, rx_q[i], exp_beats[i]); end
            end
        end
        flush_to = 32'd0;
        repeat (3) @(negedge clk);
        push32(1, 201);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus32.RvviAxiWvalid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL flush_disabled: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_gap_reset();
        int idle, acc, vcnt, lcnt;
        bit saw_last;
        gap_dly = 32'd5;
        bus32.RvviAxiWready = 1'b0;
        push_acc = 0;
        push32(10, 300);
        n_cmp++;
        if (push_acc !== 10) begin n_bad++; $display("FAIL gap_pushed: got %0d want 10", push_acc); end
        rx32(-1, 0, 200);
        build_frame(4, 64'd7);
        n_cmp++;
        if (rx_q.size() !== 51) begin n_bad++; $display("FAIL gap_len: got %0d want 51", rx_q.size()); end
        if (rx_q.size() == 51) begin
            for (int i = 0; i < 51; i++) begin
                n_cmp++;
                if (rx_q[i] !== exp_beats[i]) begin n_bad++; $display("FAIL gap_beat%0d: got %h want %h", i, rx_q[i], exp_beats[i]); end
            end
        end
        idle = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            bus32.RvviAxiWready = 1'b0;
            #1;
            if (bus32.RvviAxiWvalid === 1'b1) break;
            idle++;
        end
        n_cmp++;
        if (idle < 6 || idle > 8) begin n_bad++; $display("FAIL gap_idle: got %0d cycles want 6..8", idle); end
        acc = 0; saw_last = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            bus32.RvviAxiWready = 1'b1;
            #1;
            if (bus32.RvviAxiWvalid === 1'b1) begin
                acc++;
                if (bus32.RvviAxiWlast === 1'b1) saw_last = 1;
            end
            if (acc == 10) break;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if ({saw_last, bus32.RvviAxiWvalid, bus32.RvviAxiWlast} !== 3'b000) begin
            n_bad++; $display("FAIL reset_abort: got last/valid/wlast %b want 000", {saw_last, bus32.RvviAxiWvalid, bus32.RvviAxiWlast});
        end
        n_cmp++;
        if (fc32 !== 64'd0) begin n_bad++; $display("FAIL reset_mid_framecount: got %0d want 0", fc32); end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        flush_to = 32'd5;
        vcnt = 0; lcnt = 0;
        repeat (120) begin
            @(negedge clk);
            #1;
            if (bus32.RvviAxiWvalid === 1'b1) vcnt++;
            if (bus32.RvviAxiWlast === 1'b1) lcnt++;
        end
        n_cmp++;
        if (vcnt !== 0 || lcnt !== 0) begin n_bad++; $display("FAIL reset_discard: got valid %0d wlast %0d want 0/0", vcnt, lcnt); end
        n_cmp++;
        if (bus32.RvviReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b want 1", bus32.RvviReady); end
    endtask

    initial begin
        reset               = 1'b1;
        gap_dly             = 32'd0;
        flush_to            = 32'd0;
        bus32.rvvi          = '0;
        bus32.RvviValid     = 1'b0;
        bus32.RvviAxiWready = 1'b1;
        bus64.rvvi          = '0;
        bus64.RvviValid     = 1'b0;
        bus64.RvviAxiWready = 1'b0;
        test_reset();
        test_bus64();
        test_full_frame();
        test_backpressure();
        test_fifo_full();
        test_flush();
        test_gap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule

// File: doc/rvvi_frame_packer.md
# rvvi_frame_packer

Buffers RVVI trace records from the core in a FIFO and packs up to `INSTRS_PER_FRAME` records into each Ethernet frame. Frames go out as AXI4 write-data bursts of parameterised width toward the MAC. It generalises the single-record packetizer: configurable bus width, record buffering with backpressure instead of a core stall, multi-record frames, a partial-frame flush timeout, and an internal frame counter.

## Interface
Parameters:
- `RVVI_WIDTH`, 328: bits per RVVI record.
- `DATA_WIDTH`, 32: AXI data width; 32 or 64 only.
- `FIFO_DEPTH`, 16: record FIFO depth; power of two, ≥ `INSTRS_PER_FRAME`.
- `INSTRS_PER_FRAME`, 4: maximum records per frame; range 1..255.
- `INIT_TIME_OUT`, 32'd4: post-reset PHY settle cycles.

Derived values:
- `HEAD_BITS` = 208.
- `HEAD_WORDS` = ceil(208/`DATA_WIDTH`).
- `REC_WORDS` = ceil(`RVVI_WIDTH`/`DATA_WIDTH`).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rvvi` in `RVVI_WIDTH`: record.
- `RvviValid` in 1: record offered.
- `RvviReady` out 1: FIFO not full.
- `RvviAxiWdata` out `DATA_WIDTH`: beat data.
- `RvviAxiWstrb` out `DATA_WIDTH`/8: always all ones.
- `RvviAxiWlast` out 1: last beat of frame.
- `RvviAxiWvalid` out 1: beat valid.
- `RvviAxiWready` in 1: sink ready.
- `SrcMac`, `DstMac` in 48: MAC addresses.
- `EthType`, `AckType` in 16: header fields.
- `InnerPktDelay` in 32: minimum idle cycles between frames.
- `FlushTimeout` in 32: cycles to wait before sending a partial frame; 0 disables flush.
- `FrameCount` out 64: number of completed frames.

## Operation
- **FIFO.**
  - A record is written when `RvviValid & RvviReady`.
  - `RvviReady = ~full`. The FIFO is never written when full and never read when empty.
  - Simultaneous push and pop when full: the push is refused (ready is low), the pop proceeds.
- **Header.** Bit 0 is sent first, in beat 0 bits [7:0]. Header = {`NInstr`[7:0], 8'h00, `FrameCount`, `AckType`, `EthType`, `DstMac`, `SrcMac`}. Zero-pad to `HEAD_WORDS`·`DATA_WIDTH`.
- **Records.** Each record is zero-padded to `REC_WORDS`·`DATA_WIDTH` and sent low word first.
- **Frame length.** `HEAD_WORDS` + `NInstr`·`REC_WORDS` beats.
- **States:**
  - **STARTUP.** Count from reset. Go to COLLECT when count == `INIT_TIME_OUT`. `RvviReady` is active here; records buffer.
  - **COLLECT.**
    - If occupancy ≥ `INSTRS_PER_FRAME`: latch `NInstr` = `INSTRS_PER_FRAME`, go to HEADER.
    - Else if occupancy > 0, `FlushTimeout` ≠ 0 and the idle timer ≥ `FlushTimeout`: latch `NInstr` = occupancy, go to HEADER.
    - The idle timer clears whenever occupancy is 0 or on entry to COLLECT.
  - **HEADER.** Beat counter advances on `Wvalid & Wready`. After beat `HEAD_WORDS`-1 accepts, go to RECORD.
  - **RECORD.**
    - Data comes from the FIFO head.
    - The head pops on acceptance of word `REC_WORDS`-1 of each record.
    - After the last record's last word accepts, go to GAP. `FrameCount` increments in that same cycle.
  - **GAP.** Counter from 0. Go to COLLECT when count ≥ `InnerPktDelay`; `InnerPktDelay` = 0 gives one GAP cycle.
- `RvviAxiWvalid` = 1 in HEADER and RECORD only.
- `RvviAxiWlast` = 1 on the final beat of the frame.
- `FrameCount` wraps modulo 2^64.
- Records pushed during a frame are held for later frames and never alter the frame in flight. `NInstr` is fixed at HEADER entry.

## Timing
- **Reset values.** State STARTUP; FIFO empty; `RvviReady`=1; `RvviAxiWvalid`=0; `RvviAxiWlast`=0; `RvviAxiWdata`=0; `RvviAxiWstrb`=all ones; `FrameCount`=0; all counters 0.
- **Reset mid-frame.** Abort the frame without asserting `Wlast`. Discard the FIFO contents. Return to STARTUP.
- **Record latency.** A record pushed in cycle t is countable for frame launch in cycle t+1.
- **Header latency.** When the occupancy threshold is met in COLLECT, `Wvalid` rises in the next cycle.
- **AXI handshake.** While `Wvalid`=1 and `Wready`=0, `Wdata` and `Wlast` hold stable. No combinational path from `Wready` to `Wvalid`.
- **Throughput.** With `Wready` held at 1, a full frame takes exactly `HEAD_WORDS` + `INSTRS_PER_FRAME`·`REC_WORDS` consecutive cycles.
- **Inputs sampled at HEADER entry.** `SrcMac`, `DstMac`, `EthType`, `AckType` and `FrameCount` are registered when HEADER is entered.
- **Inputs sampled live.** `InnerPktDelay` and `FlushTimeout` are sampled each cycle.

## Test plan
- **Full frame, 32-bit bus.** `DATA_WIDTH`=32, `RVVI_WIDTH`=328, `INSTRS_PER_FRAME`=4. Push 4 records back-to-back with `Wready`=1 → 7+4·11 = 51 beats. `Wlast` only on beat 50. `NInstr`=4 in header bits [207:200]. `FrameCount` goes 0→1.
- **64-bit bus.** `DATA_WIDTH`=64, record pattern `RVVI_WIDTH`'h…A5 → `HEAD_WORDS`=4, `REC_WORDS`=6. Record 0 bits [63:0] appear on beat 4. Upper pad bits are zero.
- **Backpressure.** Drop `Wready` for 3 cycles mid-record → `Wdata`/`Wlast` stay stable. No beat is lost or duplicated. The FIFO pops once per record.
- **FIFO full.** With `FIFO_DEPTH`=16, hold `Wready`=0 during a frame and push 20 records → `RvviReady` falls after occupancy reaches 16. All accepted records later arrive in order.
- **Flush.** `FlushTimeout`=10, push 1 record → a frame launches 10 cycles after the push with `NInstr`=1 and length `HEAD_WORDS`+`REC_WORDS`. With `FlushTimeout`=0 → no frame is sent.
- **Gap and reset.** `InnerPktDelay`=5 → ≥ 6 idle cycles between `Wlast` and the next `Wvalid`. Assert `reset` on beat 10 → `Wvalid`=0 and `FrameCount`=0 next cycle, and no `Wlast` is issued.
